// File: rtl/scoreboard_pkg.sv
// Shared definitions for the multi-player scoreboard controller:
// game-state encoding, player-index width and parameter legality helper.
package scoreboard_pkg;

    localparam int PID_W       = 2;
    localparam int MIN_PLAYERS = 2;
    localparam int MAX_PLAYERS = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_WON  = 2'd2
    } state_e;

    // True when the controller configuration is within its supported range.
    function automatic bit cfg_legal(input int num_players, input int win_margin,
                                     input int debounce_cycles);
        return (num_players >= MIN_PLAYERS) && (num_players <= MAX_PLAYERS) &&
               (win_margin >= 1) && (debounce_cycles >= 1);
    endfunction

endpackage

// File: rtl/scoreboard_multi_controller_button_debouncer.sv
// Per-button conditioning: 2-flop synchroniser, stability counter that
// flips the debounced level after DEBOUNCE_CYCLES disagreeing samples,
// and a registered one-cycle pulse on each rising edge of that level.
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic raw_i,
    output logic level_o,
    output logic press_o
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             sync1_r;
    logic             sync2_r;
    logic             level_r;
    logic             level_d_r;
    logic             press_r;
    logic [CNT_W-1:0] cnt_r;

    // Bring the asynchronous button into the clock domain.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= raw_i;
            sync2_r <= sync1_r;
        end
    end

    // Count consecutive samples that disagree with the level; flip on the last one.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_r   <= '0;
            level_r <= 1'b0;
        end else if (sync2_r == level_r) begin
            cnt_r <= '0;
        end else if (cnt_r == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            cnt_r   <= '0;
            level_r <= ~level_r;
        end else begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

    // Registered rising-edge detector on the debounced level.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            level_d_r <= 1'b0;
            press_r   <= 1'b0;
        end else begin
            level_d_r <= level_r;
            press_r   <= level_r & ~level_d_r;
        end
    end

    assign level_o = level_r;
    assign press_o = press_r;

endmodule

// File: rtl/scoreboard_multi_controller.sv
// Multi-player scoreboard: debounced buttons, saturating score counters,
// win detection (target + margin) and an IDLE/PLAY/WON game FSM.
// Optional macro SCOREBOARD_UNDO_EN adds undo_i and a one-deep history
// of the players credited in the last scoring cycle.
module scoreboard_multi_controller
    import scoreboard_pkg::*;
#(
    parameter int NUM_PLAYERS     = 2,
    parameter int SCORE_W         = 8,
    parameter int WIN_SCORE       = 11,
    parameter int WIN_MARGIN      = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [NUM_PLAYERS-1:0]         btn_i,
    input  logic                           new_game_i,
`ifdef SCOREBOARD_UNDO_EN
    input  logic                           undo_i,
`endif
    output logic [NUM_PLAYERS*SCORE_W-1:0] scores_o,
    output logic [NUM_PLAYERS-1:0]         point_o,
    output logic                           winner_valid_o,
    output logic [PID_W-1:0]               winner_o,
    output logic [1:0]                     state_o
);

    if (!cfg_legal(NUM_PLAYERS, WIN_MARGIN, DEBOUNCE_CYCLES)) begin : g_cfg_err
        $error("scoreboard_multi_controller: illegal parameter combination");
    end

    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    logic [NUM_PLAYERS-1:0] btn_press_s;
    logic [NUM_PLAYERS-1:0] btn_level_s;
    logic                   ng_press_s;
    logic                   ng_level_s;
    logic                   levels_unused_s;

    state_e                 state_r, state_nxt_s;
    logic [SCORE_W-1:0]     score_r     [NUM_PLAYERS];
    logic [SCORE_W-1:0]     score_nxt_s [NUM_PLAYERS];
    logic [NUM_PLAYERS-1:0] point_r, point_nxt_s;
    logic [PID_W-1:0]       winner_r, winner_nxt_s;
    logic                   wv_r, wv_nxt_s;
    logic                   cand_s;

    for (genvar k = 0; k < NUM_PLAYERS; k++) begin : g_btn
        button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
            .clk_i  (clk_i),
            .rst_i  (rst_i),
            .raw_i  (btn_i[k]),
            .level_o(btn_level_s[k]),
            .press_o(btn_press_s[k])
        );
    end

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_new_game (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .raw_i  (new_game_i),
        .level_o(ng_level_s),
        .press_o(ng_press_s)
    );

`ifdef SCOREBOARD_UNDO_EN
    logic                   undo_press_s;
    logic                   undo_level_s;
    logic [NUM_PLAYERS-1:0] hist_mask_r, hist_mask_nxt_s;
    logic                   hist_valid_r, hist_valid_nxt_s;

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_undo (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .raw_i  (undo_i),
        .level_o(undo_level_s),
        .press_o(undo_press_s)
    );

    assign levels_unused_s = ^{btn_level_s, ng_level_s, undo_level_s};

    // History of the last scoring cycle, consumed by a single undo.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hist_mask_r  <= '0;
            hist_valid_r <= 1'b0;
        end else begin
            hist_mask_r  <= hist_mask_nxt_s;
            hist_valid_r <= hist_valid_nxt_s;
        end
    end
`else
    assign levels_unused_s = ^{btn_level_s, ng_level_s};
`endif

    // Game state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Score, point-pulse and winner registers driving the outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k < NUM_PLAYERS; k++) begin
                score_r[k] <= '0;
            end
            point_r  <= '0;
            winner_r <= '0;
            wv_r     <= 1'b0;
        end else begin
            score_r  <= score_nxt_s;
            point_r  <= point_nxt_s;
            winner_r <= winner_nxt_s;
            wv_r     <= wv_nxt_s;
        end
    end

    // Next-state logic: new game > undo > scoring; win checked on the updated scores.
    always_comb begin
        state_nxt_s  = state_r;
        score_nxt_s  = score_r;
        point_nxt_s  = '0;
        winner_nxt_s = winner_r;
        wv_nxt_s     = wv_r;
        cand_s       = 1'b0;
`ifdef SCOREBOARD_UNDO_EN
        hist_mask_nxt_s  = hist_mask_r;
        hist_valid_nxt_s = hist_valid_r;
`endif
        if (ng_press_s) begin
            state_nxt_s  = ST_IDLE;
            for (int k = 0; k < NUM_PLAYERS; k++) begin
                score_nxt_s[k] = '0;
            end
            winner_nxt_s = '0;
            wv_nxt_s     = 1'b0;
`ifdef SCOREBOARD_UNDO_EN
            hist_mask_nxt_s  = '0;
            hist_valid_nxt_s = 1'b0;
        end else if (undo_press_s) begin
            if (hist_valid_r) begin
                for (int k = 0; k < NUM_PLAYERS; k++) begin
                    if (hist_mask_r[k]) begin
                        score_nxt_s[k] = score_r[k] - SCORE_W'(1);
                    end else begin
                        score_nxt_s[k] = score_r[k];
                    end
                end
                hist_valid_nxt_s = 1'b0;
                winner_nxt_s     = '0;
                wv_nxt_s         = 1'b0;
                if (state_r == ST_WON) begin
                    state_nxt_s = ST_PLAY;
                end else begin
                    state_nxt_s = state_r;
                end
            end else begin
                hist_valid_nxt_s = 1'b0;
            end
`endif
        end else begin
            case (state_r)
                ST_IDLE, ST_PLAY: begin
                    if (|btn_press_s) begin
                        state_nxt_s = ST_PLAY;
                        for (int k = 0; k < NUM_PLAYERS; k++) begin
                            if (btn_press_s[k] && (score_r[k] != SCORE_MAX)) begin
                                score_nxt_s[k] = score_r[k] + SCORE_W'(1);
                                point_nxt_s[k] = 1'b1;
                            end else begin
                                score_nxt_s[k] = score_r[k];
                            end
                        end
`ifdef SCOREBOARD_UNDO_EN
                        if (|point_nxt_s) begin
                            hist_mask_nxt_s  = point_nxt_s;
                            hist_valid_nxt_s = 1'b1;
                        end else begin
                            hist_valid_nxt_s = hist_valid_r;
                        end
`endif
                        for (int k = 0; k < NUM_PLAYERS; k++) begin
                            cand_s = (int'(score_nxt_s[k]) >= WIN_SCORE);
                            for (int j = 0; j < NUM_PLAYERS; j++) begin
                                if ((j != k) &&
                                    (int'(score_nxt_s[k]) < int'(score_nxt_s[j]) + WIN_MARGIN)) begin
                                    cand_s = 1'b0;
                                end else begin
                                    cand_s = cand_s;
                                end
                            end
                            if (cand_s) begin
                                state_nxt_s  = ST_WON;
                                winner_nxt_s = PID_W'(k);
                                wv_nxt_s     = 1'b1;
                            end else begin
                                wv_nxt_s = wv_nxt_s;
                            end
                        end
                    end else begin
                        state_nxt_s = state_r;
                    end
                end
                ST_WON: begin
                    state_nxt_s = ST_WON;
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end
    end

    for (genvar k = 0; k < NUM_PLAYERS; k++) begin : g_flat
        assign scores_o[k*SCORE_W +: SCORE_W] = score_r[k];
    end

    assign point_o        = point_r;
    assign winner_o       = winner_r;
    assign winner_valid_o = wv_r;
    assign state_o        = state_r;

endmodule

// File: tb/tb_scoreboard_multi_controller.sv
// Self-checking bench for scoreboard_multi_controller: a 2-player instance
// checked against a score-keeping reference model, plus a 3-player 4-bit
// instance for saturation. Undo scenarios compile in with SCOREBOARD_UNDO_EN.
module tb_scoreboard_multi_controller;

    localparam int NP   = 2;
    localparam int SW   = 8;
    localparam int WIN  = 11;
    localparam int MARG = 2;
    localparam int DB   = 4;
    localparam int HOLD = DB + 4;
    localparam int SMAX = 255;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NP-1:0]        btn;
    logic                 ng;
    logic                 undo;
    logic [NP*SW-1:0]     scores;
    logic [NP-1:0]        point;
    logic                 wv;
    logic [1:0]           winner;
    logic [1:0]           state;

    logic [2:0]           btn3;
    logic                 ng3;
    logic                 undo3;
    logic [11:0]          scores3;
    logic [2:0]           point3;
    logic                 wv3;
    logic [1:0]           winner3;
    logic [1:0]           state3;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    int m_score [NP];
    int m_inc   [NP];
    int m_state;
    int m_winner;
    int m_hist  [NP];
    bit m_hist_valid;

    int           pulses [NP];
    logic [NP-1:0] last_point;

    always #5 clk = ~clk;

    scoreboard_multi_controller #(
        .NUM_PLAYERS(NP), .SCORE_W(SW), .WIN_SCORE(WIN),
        .WIN_MARGIN(MARG), .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clk_i(clk), .rst_i(rst), .btn_i(btn), .new_game_i(ng),
`ifdef SCOREBOARD_UNDO_EN
        .undo_i(undo),
`endif
        .scores_o(scores), .point_o(point), .winner_valid_o(wv),
        .winner_o(winner), .state_o(state)
    );

    scoreboard_multi_controller #(
        .NUM_PLAYERS(3), .SCORE_W(4), .WIN_SCORE(20),
        .WIN_MARGIN(MARG), .DEBOUNCE_CYCLES(DB)
    ) dut3 (
        .clk_i(clk), .rst_i(rst), .btn_i(btn3), .new_game_i(ng3),
`ifdef SCOREBOARD_UNDO_EN
        .undo_i(undo3),
`endif
        .scores_o(scores3), .point_o(point3), .winner_valid_o(wv3),
        .winner_o(winner3), .state_o(state3)
    );

    function automatic logic [SW-1:0] dscore(input int k);
        return scores[k*SW +: SW];
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Apply the game rules to one button event.
    function automatic void model_step(input logic [NP-1:0] mask, input bit ngv, input bit undov);
        bit any;
        bit ok;
        for (int k = 0; k < NP; k++) m_inc[k] = 0;
        if (ngv) begin
            for (int k = 0; k < NP; k++) m_score[k] = 0;
            m_state = 0; m_winner = 0; m_hist_valid = 0;
        end else if (undov) begin
            if (m_hist_valid) begin
                for (int k = 0; k < NP; k++) m_score[k] -= m_hist[k];
                m_hist_valid = 0;
                if (m_state == 2) m_state = 1;
                m_winner = 0;
            end
        end else if (m_state != 2 && mask != '0) begin
            any = 0;
            for (int k = 0; k < NP; k++) begin
                if (mask[k] && m_score[k] < SMAX) begin
                    m_score[k]++; m_inc[k] = 1; any = 1;
                end
            end
            if (any) begin
                for (int k = 0; k < NP; k++) m_hist[k] = m_inc[k];
                m_hist_valid = 1;
            end
            m_state = 1;
            for (int k = 0; k < NP; k++) begin
                ok = (m_score[k] >= WIN);
                for (int j = 0; j < NP; j++)
                    if (j != k && m_score[k] < m_score[j] + MARG) ok = 0;
                if (ok) begin m_state = 2; m_winner = k; end
            end
        end
    endfunction

    // Hold a button combination long enough to register, release, and update the model.
    task automatic press(input logic [NP-1:0] mask, input logic ngv, input logic undov);
        btn = mask; ng = ngv; undo = undov;
        for (int k = 0; k < NP; k++) pulses[k] = 0;
        last_point = '0;
        repeat (HOLD) begin
            tick;
            for (int k = 0; k < NP; k++) pulses[k] += int'(point[k]);
            if (point != '0) last_point = point;
        end
        btn = '0; ng = 1'b0; undo = 1'b0;
        repeat (HOLD) begin
            tick;
            for (int k = 0; k < NP; k++) pulses[k] += int'(point[k]);
            if (point != '0) last_point = point;
        end
        model_step(mask, ngv, undov);
    endtask

    task automatic test_reset;
        btn = '0; ng = 1'b0; undo = 1'b0; btn3 = '0; ng3 = 1'b0; undo3 = 1'b0;
        rst = 1'b1;
        repeat (3) tick;
        n_tests++; if (scores !== '0) begin n_fail++; $display("FAIL reset_scores got %h exp 0", scores); end
        n_tests++; if (point !== '0) begin n_fail++; $display("FAIL reset_point got %b exp 0", point); end
        n_tests++; if (state !== 2'd0) begin n_fail++; $display("FAIL reset_state got %0d exp 0", state); end
        n_tests++; if ({wv, winner} !== 3'b000) begin n_fail++; $display("FAIL reset_winner got %b%b exp 000", wv, winner); end
        rst = 1'b0;
        tick;
        for (int k = 0; k < NP; k++) begin m_score[k] = 0; m_hist[k] = 0; end
        m_state = 0; m_winner = 0; m_hist_valid = 0;
    endtask

    task automatic test_latency_glitch;
        int cnt;
        btn = 2'b01;
        repeat (DB + 3) tick;
        n_tests++; if (dscore(0) !== 8'd0) begin n_fail++; $display("FAIL lat_early got %0d exp 0", dscore(0)); end
        n_tests++; if (state !== 2'd0) begin n_fail++; $display("FAIL lat_state_early got %0d exp 0", state); end
        tick;
        n_tests++; if (dscore(0) !== 8'd1) begin n_fail++; $display("FAIL lat_score got %0d exp 1", dscore(0)); end
        n_tests++; if (point !== 2'b01) begin n_fail++; $display("FAIL lat_point got %b exp 01", point); end
        n_tests++; if (state !== 2'd1) begin n_fail++; $display("FAIL lat_state got %0d exp 1", state); end
        tick;
        n_tests++; if (point !== 2'b00) begin n_fail++; $display("FAIL lat_point_width got %b exp 00", point); end
        repeat (10) tick;
        btn = '0;
        repeat (HOLD) tick;
        model_step(2'b01, 1'b0, 1'b0);
        // 3-cycle glitch on player 1
        cnt = 0;
        btn = 2'b10;
        repeat (3) begin tick; cnt += int'(point != '0); end
        btn = '0;
        repeat (12) begin tick; cnt += int'(point != '0); end
        n_tests++; if (cnt !== 0) begin n_fail++; $display("FAIL glitch_point got %0d pulses exp 0", cnt); end
        n_tests++; if (dscore(1) !== 8'd0 || dscore(0) !== 8'd1) begin
            n_fail++; $display("FAIL glitch_score got %0d-%0d exp 1-0", dscore(0), dscore(1)); end
    endtask

    task automatic test_win_straight;
        press(2'b00, 1'b1, 1'b0);
        for (int i = 0; i < 11; i++) begin
            press(2'b01, 1'b0, 1'b0);
            n_tests++;
            if (dscore(0) !== 8'(m_score[0]) || state !== 2'(m_state) || pulses[0] !== 1) begin
                n_fail++; $display("FAIL straight_%0d got score %0d state %0d pulses %0d exp %0d %0d 1",
                                   i, dscore(0), state, pulses[0], m_score[0], m_state); end
        end
        n_tests++; if ({state, wv, winner} !== {2'd2, 1'b1, 2'd0}) begin
            n_fail++; $display("FAIL straight_won got state %0d wv %b win %0d exp 2 1 0", state, wv, winner); end
        press(2'b10, 1'b0, 1'b0);
        n_tests++; if (dscore(0) !== 8'd11 || dscore(1) !== 8'd0 || pulses[1] !== 0) begin
            n_fail++; $display("FAIL won_ignore got %0d-%0d pulses %0d exp 11-0 0", dscore(0), dscore(1), pulses[1]); end
    endtask

    task automatic test_deuce;
        logic [NP-1:0] seq [4];
        int            exp_state [4];
        seq = '{2'b10, 2'b01, 2'b10, 2'b10};
        exp_state = '{1, 1, 1, 2};
        press(2'b00, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            press(2'b01, 1'b0, 1'b0);
            press(2'b10, 1'b0, 1'b0);
        end
        n_tests++; if (dscore(0) !== 8'd10 || dscore(1) !== 8'd10 || state !== 2'd1) begin
            n_fail++; $display("FAIL deuce_10_10 got %0d-%0d state %0d exp 10-10 1", dscore(0), dscore(1), state); end
        for (int i = 0; i < 4; i++) begin
            press(seq[i], 1'b0, 1'b0);
            n_tests++;
            if (state !== 2'(exp_state[i]) || state !== 2'(m_state)) begin
                n_fail++; $display("FAIL deuce_step%0d got state %0d exp %0d", i, state, exp_state[i]); end
        end
        n_tests++; if ({dscore(0), dscore(1), wv, winner} !== {8'd11, 8'd13, 1'b1, 2'd1}) begin
            n_fail++; $display("FAIL deuce_final got %0d-%0d wv %b win %0d exp 11-13 1 1",
                               dscore(0), dscore(1), wv, winner); end
    endtask

    task automatic test_simultaneous;
        press(2'b00, 1'b1, 1'b0);
        repeat (3) press(2'b11, 1'b0, 1'b0);
        press(2'b11, 1'b0, 1'b0);
        n_tests++; if (dscore(0) !== 8'd4 || dscore(1) !== 8'd4) begin
            n_fail++; $display("FAIL simul_score got %0d-%0d exp 4-4", dscore(0), dscore(1)); end
        n_tests++; if (last_point !== 2'b11 || pulses[0] !== 1 || pulses[1] !== 1) begin
            n_fail++; $display("FAIL simul_point got %b (%0d,%0d) exp 11 (1,1)", last_point, pulses[0], pulses[1]); end
        press(2'b01, 1'b1, 1'b0);
        n_tests++; if (scores !== '0 || state !== 2'd0 || pulses[0] !== 0) begin
            n_fail++; $display("FAIL ng_priority got %h state %0d pulses %0d exp 0 0 0", scores, state, pulses[0]); end
    endtask

    task automatic test_random;
        logic [NP-1:0] mask;
        logic          ngv;
        logic          undov;
        press(2'b00, 1'b1, 1'b0);
        for (int i = 0; i < 40; i++) begin
            mask  = NP'($urandom_range(0, 3));
            ngv   = ($urandom_range(0, 11) == 0);
            undov = 1'b0;
`ifdef SCOREBOARD_UNDO_EN
            undov = ($urandom_range(0, 5) == 0);
`endif
            press(mask, ngv, undov);
            n_tests++;
            if (dscore(0) !== 8'(m_score[0]) || dscore(1) !== 8'(m_score[1]) ||
                state !== 2'(m_state) || wv !== (m_state == 2) || winner !== 2'(m_winner) ||
                pulses[0] !== m_inc[0] || pulses[1] !== m_inc[1]) begin
                n_fail++;
                $display("FAIL random_%0d got %0d-%0d st %0d wv %b w %0d p %0d%0d exp %0d-%0d st %0d w %0d p %0d%0d",
                         i, dscore(0), dscore(1), state, wv, winner, pulses[0], pulses[1],
                         m_score[0], m_score[1], m_state, m_winner, m_inc[0], m_inc[1]);
            end
        end
    endtask

    task automatic test_saturation;
        int cnt;
        int exp_score;
        exp_score = 0;
        for (int i = 0; i < 17; i++) begin
            cnt = 0;
            btn3 = 3'b100;
            repeat (HOLD) begin tick; cnt += int'(point3[2]); end
            btn3 = '0;
            repeat (HOLD) begin tick; cnt += int'(point3[2]); end
            n_tests++;
            if (scores3[11:8] !== 4'((exp_score < 15) ? exp_score + 1 : 15) || cnt !== ((exp_score < 15) ? 1 : 0)) begin
                n_fail++; $display("FAIL sat_%0d got %0d pulses %0d exp %0d pulses %0d", i, scores3[11:8], cnt,
                                   (exp_score < 15) ? exp_score + 1 : 15, (exp_score < 15) ? 1 : 0);
            end
            if (exp_score < 15) exp_score++;
        end
        n_tests++; if (scores3[7:0] !== 8'd0 || state3 !== 2'd1 || wv3 !== 1'b0) begin
            n_fail++; $display("FAIL sat_others got %h state %0d wv %b exp 00 1 0", scores3[7:0], state3, wv3); end
    endtask

`ifdef SCOREBOARD_UNDO_EN
    task automatic test_undo;
        press(2'b00, 1'b1, 1'b0);
        for (int i = 0; i < 9; i++) begin
            press(2'b01, 1'b0, 1'b0);
            press(2'b10, 1'b0, 1'b0);
        end
        press(2'b01, 1'b0, 1'b0);
        press(2'b01, 1'b0, 1'b0);
        n_tests++; if ({dscore(0), dscore(1), state, wv} !== {8'd11, 8'd9, 2'd2, 1'b1}) begin
            n_fail++; $display("FAIL undo_setup got %0d-%0d st %0d wv %b exp 11-9 2 1", dscore(0), dscore(1), state, wv); end
        press(2'b00, 1'b0, 1'b1);
        n_tests++; if ({dscore(0), dscore(1), state, wv, winner} !== {8'd10, 8'd9, 2'd1, 1'b0, 2'd0} ||
                       pulses[0] !== 0) begin
            n_fail++; $display("FAIL undo_first got %0d-%0d st %0d wv %b w %0d exp 10-9 1 0 0",
                               dscore(0), dscore(1), state, wv, winner); end
        press(2'b00, 1'b0, 1'b1);
        n_tests++; if ({dscore(0), dscore(1), state} !== {8'd10, 8'd9, 2'd1} ||
                       dscore(0) !== 8'(m_score[0])) begin
            n_fail++; $display("FAIL undo_second got %0d-%0d st %0d exp 10-9 1", dscore(0), dscore(1), state); end
    endtask
`endif

    initial begin
        test_reset;
        test_latency_glitch;
        test_win_straight;
        test_deuce;
        test_simultaneous;
        test_saturation;
`ifdef SCOREBOARD_UNDO_EN
        test_undo;
`endif
        test_random;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/scoreboard_multi_controller.md
Name: scoreboard_multi_controller

Overview:
- Parametrised next-generation scoreboard controller for 2..4 players.
- Adds per-button synchronisation and debounce, win detection with a configurable target and winning margin, a game-state FSM and a new-game restart.
- Drives per-player scores to the display controller (flattened bus) plus winner and state status for the uio outputs.

Parameters:
- NUM_PLAYERS, 2, number of player buttons/score counters (legal 2..4).
- SCORE_W, 8, width of each binary score counter.
- WIN_SCORE, 11, minimum score needed to win.
- WIN_MARGIN, 2, required lead over every other player (legal >= 1).
- DEBOUNCE_CYCLES, 4, consecutive stable synced samples needed before the debounced level changes (legal >= 1).

Ports:
- clk_i  input  1  system clock.
- rst_i  input  1  asynchronous active-high reset.
- btn_i  input  NUM_PLAYERS  raw asynchronous player buttons; bit k = player k.
- new_game_i  input  1  raw asynchronous new-game button.
- scores_o  output  NUM_PLAYERS*SCORE_W  player k score at bits [k*SCORE_W +: SCORE_W].
- point_o  output  NUM_PLAYERS  one-cycle pulse per player whose score changed this cycle.
- winner_valid_o  output  1  high while in WON.
- winner_o  output  2  winning player index; 0 when winner_valid_o is low.
- state_o  output  2  FSM state encoding: IDLE=0, PLAY=1, WON=2.

Behaviour:
- Reset:
  - Clock is clk_i; reset rst_i is asynchronous, active-high.
  - On reset, all outputs are 0, state is IDLE, and debouncer levels, counters and history are cleared.
- Input conditioning, applied to every button including new_game_i and undo_i:
  - 2-flop synchroniser.
  - Debounce counter:
    - Resets whenever the synced sample equals the current debounced level.
    - Otherwise increments.
    - When the counter reaches DEBOUNCE_CYCLES, the level flips and the counter clears.
  - A rising edge of the debounced level produces a one-cycle press pulse.
- Latency: a clean, held press updates scores_o and pulses point_o exactly DEBOUNCE_CYCLES+3 cycles after the first clk_i edge that samples btn_i high. Glitches shorter than DEBOUNCE_CYCLES cycles produce no pulse.
- FSM:
  - IDLE --any press--> PLAY. The point is counted in the same cycle.
  - PLAY --win condition true after update--> WON.
  - WON: player presses are ignored and point_o stays 0.
  - Any state --new-game press--> IDLE. Scores and history are cleared in the same cycle, and any simultaneous player press is dropped.
- Scoring:
  - All player presses occurring in the same cycle are counted together, each +1.
  - A score at 2^SCORE_W-1 saturates: the score holds and its point_o bit stays low.
- Win condition: player k has score >= WIN_SCORE and score >= every other score + WIN_MARGIN.
  - Because WIN_MARGIN >= 1, at most one player can satisfy it.
  - winner_o is latched on entry to WON.
  - Deuce play is unbounded, e.g. 10-10 continues to 12-10.

Optional Feature:
- Macro: SCOREBOARD_UNDO_EN.
- With the macro defined:
  - Extra port undo_i input 1, conditioned like the other buttons.
  - A one-deep history register holds the mask of players credited in the last scoring cycle, plus a valid flag.
  - An undo press with history valid:
    - Decrements those players.
    - Clears the valid flag.
    - Moves WON→PLAY and clears winner outputs.
    - Does not pulse point_o.
  - Undo is ignored when history is invalid, including a second consecutive undo.
  - Undo in the same cycle as a player press: undo wins and the press is dropped.
  - New-game has priority over undo.
  - Leaving IDLE via undo is not possible: after undoing the first point the state stays PLAY at 0-0.
- Without the macro: no undo_i port, no history logic.

Decomposition:
- Package scoreboard_pkg:
  - state typedef/localparams (IDLE, PLAY, WON).
  - PID_W = 2.
  - Legality checks for NUM_PLAYERS and WIN_MARGIN as constants/assertions.
- Sub-module button_debouncer (parameter DEBOUNCE_CYCLES; ports clk_i, rst_i, raw_i, level_o, press_o), instantiated once per button via generate.

Test Plan (NUM_PLAYERS=2, WIN_SCORE=11, WIN_MARGIN=2, DEBOUNCE_CYCLES=4 unless noted):
- Reset then hold btn_i[0] high 20 cycles → scores_o[7:0]=1 exactly 7 cycles after the first sampled high; point_o[0] high one cycle; state_o 0→1; 3-cycle glitch on btn_i[1] → no change.
- Drive 11-0 via 11 clean presses of player 0 → after the 11th, state_o=2, winner_valid_o=1, winner_o=0; a further btn_i[1] press leaves scores at 11-0.
- Alternate presses to 10-10, then player1, player0, player1, player1 → WON only at 13-11, winner_o=1; no WON at 11-10 or 12-11.
- Both buttons pressed in the same cycle from 3-3 → 4-4 in one cycle, point_o=2'b11; new_game_i press in the same cycle as btn_i[0] → scores 0-0, state IDLE.
- NUM_PLAYERS=3, SCORE_W=4, WIN_SCORE=20 → player 2 pressed 17 times saturates at 15; point_o[2] silent on saturated presses.
- With SCOREBOARD_UNDO_EN, from 10-9 win to 11-9 (WON), then press undo → 10-9, state PLAY, winner_valid_o=0; a second undo → no change.
